// File: rtl/inv_lshr_cmp_solver_pkg.sv
// Shared types for the lshr comparison witness solver.
// Predicate modes, FSM states and width helpers.
package inv_solver_pkg;

    typedef enum logic [1:0] {
        ULE = 2'b00,
        ULT = 2'b01,
        SLE = 2'b10,
        SLT = 2'b11
    } cmp_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        RESP = 2'b10
    } solver_state_e;

    function automatic logic [15:0] min_val(input int w);
        return 16'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/inv_lshr_cmp_solver_if.sv
// Request/response handshake bundle for the solver.
// master issues requests, slave is the solver.
interface inv_lshr_cmp_solver_if #(
    parameter int W = 4
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_s;
    logic [W-1:0] req_t;
    logic [1:0]   req_mode;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_x;
    logic         rsp_sat;
    logic [W:0]   rsp_iters;

    modport master (
        output req_valid, req_s, req_t, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_x, rsp_sat, rsp_iters
    );

    modport slave (
        input  req_valid, req_s, req_t, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_x, rsp_sat, rsp_iters
    );
endinterface

// File: rtl/inv_lshr_cmp_solver_eval.sv
// Combinational test of (x >>u s) cmp t.
// Shift amounts >= W naturally yield zero.
module lshr_cmp_eval
    import inv_solver_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  cmp_mode_e    mode,
    output logic         hit
);
    logic [W-1:0] sh;

    assign sh = x >> s;

    // decode predicate mode into one comparison
    always_comb begin
        hit = 1'b0;
        unique case (1'b1)
            mode == ULE: hit = sh <= t;
            mode == ULT: hit = sh < t;
            mode == SLE: hit = $signed(sh) <= $signed(t);
            mode == SLT: hit = $signed(sh) < $signed(t);
            default:     hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/inv_lshr_cmp_solver.sv
// Minimal-x witness solver for (x >>u s) cmp t.
// Closed-form or exhaustive search, selected by SEARCH.
module inv_lshr_cmp_solver
    import inv_solver_pkg::*;
#(
    parameter int W      = 4,
    parameter int SEARCH = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    inv_lshr_cmp_solver_if.slave bus
);
    localparam logic [W-1:0] MIN  = W'(min_val(W));
    localparam logic [W:0]   LAST = {1'b0, {W{1'b1}}};

    solver_state_e state;
    logic [W-1:0]  s_q;
    logic [W-1:0]  t_q;
    cmp_mode_e     mode_q;
    logic [W:0]    cnt;
    logic          armed;
    logic          ready_q;
    logic          valid_q;
    logic [W-1:0]  x_q;
    logic          sat_q;
    logic [W:0]    iters_q;
    logic          hit;
    logic [W-1:0]  cf_x;
    logic          cf_sat;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_x     = x_q;
    assign bus.rsp_sat   = sat_q;
    assign bus.rsp_iters = iters_q;

    if (SEARCH != 0) begin : g_search
        lshr_cmp_eval #(.W(W)) u_eval (
            .x    (cnt[W-1:0]),
            .s    (s_q),
            .t    (t_q),
            .mode (mode_q),
            .hit  (hit)
        );
    end else begin : g_cf
        assign hit = 1'b0;
    end

    // closed-form minimal witness from latched operands
    always_comb begin
        cf_x   = '0;
        cf_sat = 1'b0;
        unique case (mode_q)
            ULE: cf_sat = 1'b1;
            ULT: cf_sat = t_q != '0;
            SLE: begin
                if (!t_q[W-1]) begin
                    cf_sat = 1'b1;
                end else if (s_q == '0) begin
                    cf_sat = 1'b1;
                    cf_x   = MIN;
                end
            end
            SLT: begin
                if (!t_q[W-1] && t_q != '0) begin
                    cf_sat = 1'b1;
                end else if (s_q == '0 && t_q != MIN) begin
                    cf_sat = 1'b1;
                    cf_x   = MIN;
                end
            end
            default: cf_sat = 1'b0;
        endcase
    end

    // request/evaluate/respond FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_q     <= '0;
            t_q     <= '0;
            mode_q  <= ULE;
            cnt     <= '0;
            armed   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            x_q     <= '0;
            sat_q   <= 1'b0;
            iters_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        s_q     <= bus.req_s;
                        t_q     <= bus.req_t;
                        mode_q  <= cmp_mode_e'(bus.req_mode);
                        cnt     <= '0;
                        armed   <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    if (SEARCH == 0) begin
                        x_q     <= cf_x;
                        sat_q   <= cf_sat;
                        iters_q <= (W+1)'(1);
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end else if (!armed) begin
                        // one setup cycle before the sweep starts
                        armed <= 1'b1;
                    end else if (hit) begin
                        x_q     <= cnt[W-1:0];
                        sat_q   <= 1'b1;
                        iters_q <= cnt + 1'b1;
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end else if (cnt == LAST) begin
                        x_q     <= '0;
                        sat_q   <= 1'b0;
                        iters_q <= cnt + 1'b1;
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/inv_lshr_cmp_solver.md
# inv_lshr_cmp_solver

Sequential, width-parametrised witness generator for the invertibility condition of logical-shift-right under a comparison predicate. Given shift amount `s`, bound `t` and a predicate mode, it returns the unsigned-minimal `x` such that `(x >>u s) cmp t` holds, or flags the instance unsatisfiable. It replaces the fixed 4-bit, single-predicate combinational Skolem tables. It sits behind a valid/ready request port in the solver back-end. It offers a one-cycle closed-form mode and an exhaustive-search mode whose results must be bit-identical; the search mode is the on-chip cross-check.

## Interface
- `W`, 4 — operand width, 2..16.
- `SEARCH`, 0 — 0: closed-form evaluation; 1: exhaustive enumeration of `x`.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — block can accept a request.
- `req_s` in W — shift amount, unsigned; `s >= W` shifts everything out.
- `req_t` in W — comparison bound.
- `req_mode` in 2 — 00 ULE, 01 ULT, 10 SLE, 11 SLT.
- `rsp_valid` out 1 — result available.
- `rsp_ready` in 1 — consumer takes the result.
- `rsp_x` out W — witness; 0 when unsat.
- `rsp_sat` out 1 — 1 means a witness exists.
- `rsp_iters` out W+1 — number of candidates evaluated; 1 in closed-form mode.

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, register `s`, `t`, `mode`, clear the candidate counter, go to EVAL.
- Closed form (`SEARCH`=0). EVAL lasts one cycle, then go to RESP. MIN = 1<<(W-1).
  - ULE: sat, x=0.
  - ULT: sat with x=0 iff t≠0.
  - SLE: if t ≥s 0 then x=0; else if s==0 then x=MIN; else unsat.
  - SLT: if t >s 0 then x=0; else if s==0 and t≠MIN then x=MIN; else unsat.
- Search (`SEARCH`=1). Each EVAL cycle tests candidate `c`, starting at 0.
  - Pass: latch x=c, sat=1, iters=c+1, go to RESP.
  - Fail with c = 2^W−1: x=0, sat=0, iters=2^W, go to RESP.
  - Otherwise c increments. The counter is W+1 bits, so it never aliases on wrap.
- The predicate `(c >>u s) cmp t` uses `s` as a full W-bit value. `s >= W` yields 0.
- RESP: `rsp_valid`=1; outputs are held stable until `rsp_ready`, then go to IDLE.
- No new request is accepted outside IDLE: `req_ready`=0 in EVAL and RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_x`=0, `rsp_sat`=0, `rsp_iters`=0.
- Request accepted at edge N:
  - `SEARCH`=0: `rsp_valid` rises after edge N+1.
  - `SEARCH`=1, sat at candidate c: `rsp_valid` rises after edge N+1+c+1.
  - `SEARCH`=1, unsat: `rsp_valid` rises after edge N+1+2^W.
- With `rsp_ready` held high: `rsp_valid` is high for exactly one cycle; `req_ready` returns on the following cycle. There is no same-cycle accept-after-response.
- Asserting `rst_n` low in any state aborts immediately to reset values; the in-flight result is discarded.
- `req_*` inputs are ignored while `req_ready`=0.

## Structure
- Shared package `inv_solver_pkg` holds:
  - `cmp_mode_e` (ULE, ULT, SLE, SLT) and `solver_state_e` (IDLE, EVAL, RESP);
  - a function returning MIN for a given width.
- Sub-module `lshr_cmp_eval` (purely combinational, parameter W) computes `(x >>u s) cmp t`.
  - Search mode instantiates it for the candidate.
  - The testbench reuses it as the reference checker.
- The closed-form logic stays in the top.

## Test plan
All scenarios use W=4 and run under both `SEARCH` values. `x`, `sat` and the FSM sequence must match between modes; only `iters` and latency differ.
- s=2, t=0101, SLE -> x=0000, sat=1. Closed form: 1 cycle. Search: iters=1.
- s=0, t=1000, SLE -> x=1000, sat=1. Search: iters=9.
- s=0, t=1000, SLT -> sat=0, x=0000. Search: iters=16, `rsp_valid` after edge N+17.
- s=2, t=1111, SLE -> sat=0. t=0000, ULT, s=5 -> sat=0.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles. Outputs stay stable and `req_ready` stays 0. A request offered meanwhile is not taken.
- Reset pulse mid-EVAL during search, then a fresh request s=1, t=0011, ULT -> clean reset values, then x=0000, sat=1.
